fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the two-stage MCU pipeline. Owns the 11-bit program counter, the 8-level hardware return stack and the instruction register (IR).
- Drives the address of the combinational Program_Rom and latches the returned 14-bit word into IR for the execute stage.
- Execute decodes IR combinationally and, in the same cycle, returns jump/call/return requests that redirect fetch and flush the prefetched word.

Parameters:
- STACK_DEPTH, 8, return-stack entries; power of two, 2..16.
- NOP_WORD, 14'h0000, word loaded into IR on flush and reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC, IR, ir_pc and ir_valid for this cycle.
- jump_en  input  1  GOTO in execute; load PC from jump_addr.
- call_en  input  1  CALL in execute; push return address, load PC from jump_addr.
- ret_en  input  1  RETURN/RETLW in execute; pop stack into PC.
- jump_addr  input  11  target for jump_en / call_en.
- rom_addr  output  11  address to Program_Rom; equals PC register.
- rom_data  input  14  word from Program_Rom, combinational on rom_addr.
- ir_out  output  14  instruction presented to execute.
- ir_pc  output  11  address the ir_out word was fetched from.
- ir_valid  output  1  0 = ir_out is a flush bubble.
- stack_ovf  output  1  sticky push-overflow flag (see Optional Feature).
- stack_unf  output  1  sticky pop-underflow flag (see Optional Feature).

Behaviour:
- Reset (async, immediate): PC=0, rom_addr=0, ir_out=NOP_WORD, ir_pc=0, ir_valid=0, sp=0, all stack entries 0, stack_ovf=0, stack_unf=0.
- Redirect is qualified: redirect = ir_valid & (ret_en | call_en | jump_en). A bubble never redirects.
- Priority: redirect > stall > normal advance.
- Among redirects, ret_en > call_en > jump_en. These requests are mutually exclusive by design; the priority defines behaviour if they are not.
- Normal advance (no redirect, stall=0), one clock edge: IR<=rom_data; ir_pc<=PC; ir_valid<=1; PC<=PC+1.
- PC arithmetic is 11-bit modulo: 0x7FF+1 = 0x000.
- Stall (no redirect): every register holds. rom_addr stays stable.
- jump_en: PC<=jump_addr; IR<=NOP_WORD; ir_valid<=0; ir_pc<=PC. The stack is untouched.
- call_en: stack[sp]<=ir_pc+1 (mod 2^11); sp<=sp+1; PC<=jump_addr; flush as for jump.
- ret_en: sp<=sp-1; PC<=stack[sp-1]; flush as for jump.
- Redirect latency: the target word appears in IR with ir_valid=1 two edges after the request edge (one bubble cycle). Stall during the bubble cycle holds the bubble.
- Stack pointer arithmetic is log2(STACK_DEPTH) bits and circular.
  - Push when STACK_DEPTH entries are live silently overwrites the oldest entry.
  - Pop when empty returns whatever the wrapped slot holds.
  - A live-entry counter (0..STACK_DEPTH, saturating) tracks occupancy for the flags.
- Reset asserted mid-operation aborts any redirect. The first fetch after release is address 0.
- Only the PC and stack registers feed rom_addr; there is no combinational path from the jump/call/ret inputs to rom_addr.

Optional Feature:
- Macro: FETCH_STACK_FLAGS_EN.
- Defined:
  - stack_ovf sets on a call when the live count already equals STACK_DEPTH.
  - stack_unf sets on a ret when the live count is 0.
  - Both flags are sticky and cleared only by rst.
- Undefined: stack_ovf and stack_unf are tied 0, the live counter is not built, and stack wrap behaviour is unchanged.

Test Plan:
- Bench ROM returns {3'b0, addr}. Release reset, no stall: ir_out sequence 0x000, 0x001, 0x002 with ir_valid=1 from the first edge; ir_pc matches the low 11 bits of ir_out.
- While ir_pc=0x005, assert jump_en with jump_addr=0x7FE -> next cycle ir_valid=0, ir_out=0x0000; following cycles ir_out=0x7FE, 0x7FF, then 0x000 (wrap).
- call_en at ir_pc=0x010 to 0x100, run 3 words, then ret_en -> after the bubble, ir_out=0x011 and fetch continues at 0x012.
- 9 nested calls, then 9 returns -> the first 8 returns yield the latest 8 return addresses in LIFO order. The 9th return repeats the newest surviving entry. With FETCH_STACK_FLAGS_EN, stack_ovf=1 after the 9th call and stack_unf=1 after the 9th return.
- Hold stall high for 4 cycles mid-stream -> rom_addr, ir_out, ir_pc unchanged. Assert jump_en together with stall -> the jump is taken and the flush occurs.
- Assert rst asynchronously mid-cycle during a bubble -> all outputs return to reset values immediately. After release, ir_out=0x000 on the first edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the two-stage MCU pipeline.
//
// Owns the 11-bit program counter, a circular hardware return stack and the
// instruction register. Drives the combinational Program_Rom and latches the
// returned word for execute. Execute answers in the same cycle with
// jump/call/return requests that redirect fetch and flush the prefetched word.
//
// Optional build macro: FETCH_STACK_FLAGS_EN
//   defined   -> sticky stack_ovf_o / stack_unf_o backed by a live-entry counter
//   undefined -> both flags tied low, no counter
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   stall_i      hold PC, IR, ir_pc and ir_valid this cycle
//   jump_en_i    GOTO in execute: PC <= jump_addr_i
//   call_en_i    CALL in execute: push ir_pc+1, PC <= jump_addr_i
//   ret_en_i     RETURN/RETLW in execute: pop stack into PC
//   jump_addr_i  jump / call target
//   rom_addr_o   Program_Rom address (the PC register)
//   rom_data_i   Program_Rom word for rom_addr_o
//   ir_out_o     instruction presented to execute
//   ir_pc_o      address ir_out_o was fetched from
//   ir_valid_o   0 while ir_out_o is a flush bubble
//   stack_ovf_o  sticky push-overflow flag
//   stack_unf_o  sticky pop-underflow flag
module fetch_stage #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jump_en_i,
    input  logic        call_en_i,
    input  logic        ret_en_i,
    input  logic [10:0] jump_addr_i,
    output logic [10:0] rom_addr_o,
    input  logic [13:0] rom_data_i,
    output logic [13:0] ir_out_o,
    output logic [10:0] ir_pc_o,
    output logic        ir_valid_o,
    output logic        stack_ovf_o,
    output logic        stack_unf_o
);

    localparam int unsigned SpW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [10:0]    pc_q, pc_d;
    logic [13:0]    ir_q, ir_d;
    logic [10:0]    ir_pc_q, ir_pc_d;
    logic           ir_valid_q, ir_valid_d;
    logic [SpW-1:0] sp_q, sp_d;
    logic [SpW-1:0] sp_dec;
    logic [10:0]    stack_q [STACK_DEPTH];

    logic redirect;
    logic do_ret;
    logic do_call;

    // A bubble in IR is not a real instruction, so it can never redirect.
    assign redirect = ir_valid_q & (ret_en_i | call_en_i | jump_en_i);
    assign do_ret   = redirect & ret_en_i;
    assign do_call  = redirect & ~ret_en_i & call_en_i;
    assign sp_dec   = sp_q - SpW'(1);

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        if (redirect) begin
            // Flush the prefetched word; the target arrives one cycle later.
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            ir_pc_d    = pc_q;
            if (do_ret) begin
                sp_d = sp_dec;
                pc_d = stack_q[sp_dec];
            end else if (do_call) begin
                sp_d = sp_q + SpW'(1);
                pc_d = jump_addr_i;
            end else begin
                pc_d = jump_addr_i;
            end
        end else if (!stall_i) begin
            ir_d       = rom_data_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= 11'd0;
            ir_q       <= NOP_WORD;
            ir_pc_q    <= 11'd0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 11'd0;
            end
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
            // Circular: a push with the stack full overwrites the oldest entry.
            if (do_call) begin
                stack_q[sp_q] <= ir_pc_q + 11'd1;
            end
        end
    end

    assign rom_addr_o = pc_q;
    assign ir_out_o   = ir_q;
    assign ir_pc_o    = ir_pc_q;
    assign ir_valid_o = ir_valid_q;

`ifdef FETCH_STACK_FLAGS_EN
    localparam logic [SpW:0] LiveMax = (SpW + 1)'(STACK_DEPTH);

    logic [SpW:0] live_q, live_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    // Occupancy only drives the flags; the pointer wraps regardless.
    always_comb begin
        live_d = live_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (do_ret) begin
            if (live_q == '0) begin
                unf_d = 1'b1;
            end else begin
                live_d = live_q - (SpW + 1)'(1);
            end
        end else if (do_call) begin
            if (live_q == LiveMax) begin
                ovf_d = 1'b1;
            end else begin
                live_d = live_q + (SpW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;
`else
    assign stack_ovf_o = 1'b0;
    assign stack_unf_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The ROM returns {3'b0, addr}, so the
// low 11 bits of every fetched word name the address it came from.
module tb_fetch_stage;

    localparam int Depth = 8;
`ifdef FETCH_STACK_FLAGS_EN
    localparam bit FlagsOn = 1'b1;
`else
    localparam bit FlagsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic        call_en = 1'b0;
    logic        ret_en = 1'b0;
    logic [10:0] jump_addr = 11'd0;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic [13:0] ir_out;
    logic [10:0] ir_pc;
    logic        ir_valid;
    logic        stack_ovf;
    logic        stack_unf;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural view of fetch, not the RTL encoding.
    int m_pc, m_ir, m_irpc, m_sp, m_live;
    bit m_valid, m_ovf, m_unf;
    int m_stk [Depth];

    always #5 clk = ~clk;

    assign rom_data = {3'b000, rom_addr};

    fetch_stage #(
        .STACK_DEPTH(Depth),
        .NOP_WORD   (14'h0000)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .stall_i    (stall),
        .jump_en_i  (jump_en),
        .call_en_i  (call_en),
        .ret_en_i   (ret_en),
        .jump_addr_i(jump_addr),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .ir_out_o   (ir_out),
        .ir_pc_o    (ir_pc),
        .ir_valid_o (ir_valid),
        .stack_ovf_o(stack_ovf),
        .stack_unf_o(stack_unf)
    );

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0;
        m_sp = 0; m_live = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < Depth; i++) m_stk[i] = 0;
    endtask

    task automatic model_edge();
        int old_pc = m_pc;
        int old_irpc = m_irpc;
        bit redir = m_valid && (ret_en || call_en || jump_en);
        if (redir) begin
            m_ir = 0; m_valid = 0; m_irpc = old_pc;
            if (ret_en) begin
                if (m_live == 0) m_unf = 1; else m_live--;
                m_sp = (m_sp + Depth - 1) % Depth;
                m_pc = m_stk[m_sp];
            end else if (call_en) begin
                if (m_live == Depth) m_ovf = 1; else m_live++;
                m_stk[m_sp] = (old_irpc + 1) % 2048;
                m_sp = (m_sp + 1) % Depth;
                m_pc = int'(jump_addr);
            end else begin
                m_pc = int'(jump_addr);
            end
        end else if (!stall) begin
            m_ir = old_pc; m_irpc = old_pc; m_valid = 1;
            m_pc = (old_pc + 1) % 2048;
        end
    endtask

    // One clock edge: advance the model alongside the DUT, then sample 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if (rom_addr !== 11'h000 || ir_out !== 14'h0000 || ir_pc !== 11'h000 ||
            ir_valid !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%h ir=%h pc=%h v=%b ovf=%b unf=%b, want all zero",
                     rom_addr, ir_out, ir_pc, ir_valid, stack_ovf, stack_unf);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_out !== 14'(i) || ir_pc !== 11'(i) || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq[%0d]: ir=%h pc=%h v=%b, want ir=%h pc=%h v=1",
                         i, ir_out, ir_pc, ir_valid, i, i);
            end
        end
    endtask

    task automatic test_jump_wrap();
        logic [13:0] exp_seq [3];
        exp_seq[0] = 14'h07FE; exp_seq[1] = 14'h07FF; exp_seq[2] = 14'h0000;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (ir_pc !== 11'h005) begin
            errors++;
            $display("FAIL jump_setup: ir_pc=%h want 005", ir_pc);
        end
        jump_en = 1'b1; jump_addr = 11'h7FE;
        tick();
        jump_en = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || ir_out !== 14'h0000 || rom_addr !== 11'h7FE) begin
            errors++;
            $display("FAIL jump_bubble: v=%b ir=%h addr=%h, want v=0 ir=0000 addr=7fe",
                     ir_valid, ir_out, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_out !== exp_seq[i] || ir_valid !== 1'b1 || ir_pc !== exp_seq[i][10:0]) begin
                errors++;
                $display("FAIL jump_wrap[%0d]: ir=%h pc=%h v=%b, want ir=%h v=1",
                         i, ir_out, ir_pc, ir_valid, exp_seq[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        jump_en = 1'b1; jump_addr = 11'h010;
        tick();
        jump_en = 1'b0;
        tick();
        checks++;
        if (ir_pc !== 11'h010 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL call_setup: ir_pc=%h v=%b want 010 v=1", ir_pc, ir_valid);
        end
        call_en = 1'b1; jump_addr = 11'h100;
        tick();
        call_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_out !== 14'(11'h100 + 11'(i)) || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL call_body[%0d]: ir=%h v=%b want %h", i, ir_out, ir_valid,
                         11'h100 + 11'(i));
            end
        end
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || rom_addr !== 11'h011) begin
            errors++;
            $display("FAIL ret_bubble: v=%b addr=%h want v=0 addr=011", ir_valid, rom_addr);
        end
        tick();
        checks++;
        if (ir_out !== 14'h0011 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL ret_land: ir=%h v=%b want 0011 v=1", ir_out, ir_valid);
        end
        tick();
        checks++;
        if (ir_out !== 14'h0012 || ir_pc !== 11'h012) begin
            errors++;
            $display("FAIL ret_cont: ir=%h pc=%h want 0012/012", ir_out, ir_pc);
        end
    endtask

    task automatic test_nested();
        logic [10:0] ra [9];
        logic [10:0] want;
        ra[0] = 11'h013;
        for (int i = 1; i < 9; i++) ra[i] = 11'(32'h200 + (i - 1) * 16 + 1);
        for (int i = 0; i < 9; i++) begin
            call_en = 1'b1; jump_addr = 11'(32'h200 + i * 16);
            tick();
            call_en = 1'b0;
            tick();
            if (i >= 7) begin
                checks++;
                if (stack_ovf !== (FlagsOn && i == 8)) begin
                    errors++;
                    $display("FAIL ovf_after_call%0d: ovf=%b want %b", i + 1, stack_ovf,
                             FlagsOn && i == 8);
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            want = (k < 8) ? ra[8 - k] : ra[8];
            ret_en = 1'b1;
            tick();
            ret_en = 1'b0;
            tick();
            checks++;
            if (ir_out !== {3'b000, want} || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL nested_ret%0d: ir=%h v=%b want %h", k + 1, ir_out, ir_valid, want);
            end
            if (k >= 7) begin
                checks++;
                if (stack_unf !== (FlagsOn && k == 8)) begin
                    errors++;
                    $display("FAIL unf_after_ret%0d: unf=%b want %b", k + 1, stack_unf,
                             FlagsOn && k == 8);
                end
            end
        end
    endtask

    task automatic test_stall();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rom_addr !== 11'(m_pc) || ir_out !== 14'(m_ir) || ir_pc !== 11'(m_irpc) ||
                ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: addr=%h ir=%h pc=%h v=%b want addr=%h ir=%h pc=%h v=1",
                         i, rom_addr, ir_out, ir_pc, ir_valid, m_pc, m_ir, m_irpc);
            end
        end
        jump_en = 1'b1; jump_addr = 11'h123;
        tick();
        jump_en = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || rom_addr !== 11'h123 || ir_out !== 14'h0000) begin
            errors++;
            $display("FAIL stall_jump: v=%b addr=%h ir=%h want v=0 addr=123 ir=0000",
                     ir_valid, rom_addr, ir_out);
        end
        tick();
        checks++;
        if (ir_valid !== 1'b0 || rom_addr !== 11'h123) begin
            errors++;
            $display("FAIL stall_bubble_hold: v=%b addr=%h want v=0 addr=123", ir_valid, rom_addr);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (ir_out !== 14'h0123 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ir=%h v=%b want 0123 v=1", ir_out, ir_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int r = int'($urandom_range(0, 9));
            stall = ($urandom_range(0, 3) == 0);
            jump_addr = 11'($urandom);
            jump_en = (r == 0) || (r == 3);
            call_en = (r == 1) || (r == 3) || (r == 4);
            ret_en = (r == 2) || (r == 4);
            tick();
            checks++;
            if (ir_out !== 14'(m_ir) || ir_pc !== 11'(m_irpc) || ir_valid !== m_valid ||
                rom_addr !== 11'(m_pc) || stack_ovf !== (FlagsOn && m_ovf) ||
                stack_unf !== (FlagsOn && m_unf)) begin
                errors++;
                $display("FAIL random[%0d]: ir=%h/%h pc=%h/%h v=%b/%b addr=%h/%h ovf=%b/%b unf=%b/%b",
                         c, ir_out, m_ir, ir_pc, m_irpc, ir_valid, m_valid, rom_addr, m_pc,
                         stack_ovf, FlagsOn && m_ovf, stack_unf, FlagsOn && m_unf);
            end
        end
        stall = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        jump_en = 1'b1; jump_addr = 11'h050;
        tick();
        jump_en = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rom_addr !== 11'h000 || ir_out !== 14'h0000 || ir_pc !== 11'h000 ||
            ir_valid !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%h ir=%h pc=%h v=%b ovf=%b unf=%b, want all zero",
                     rom_addr, ir_out, ir_pc, ir_valid, stack_ovf, stack_unf);
        end
        #3;
        rst = 1'b0;
        tick();
        checks++;
        if (ir_out !== 14'h0000 || ir_valid !== 1'b1 || ir_pc !== 11'h000 ||
            rom_addr !== 11'h001) begin
            errors++;
            $display("FAIL after_reset: ir=%h v=%b pc=%h addr=%h want 0000 1 000 001",
                     ir_out, ir_valid, ir_pc, rom_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_wrap();
        test_call_ret();
        test_nested();
        test_stall();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
